// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod serial link: frame geometry, the
// emitter FSM state encoding and the "controller absent" field value.
package gamepad_pmod_pkg;

    // Two 12-bit controllers per frame.
    localparam int unsigned GAMEPAD_BITS = 24;
    localparam int unsigned CTRL_BITS    = 12;

    // A controller slot that reads all ones means nothing is plugged in.
    localparam logic [CTRL_BITS-1:0] CTRL_ABSENT = 12'hfff;

    // Emitter waveform phases.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Clocks from the accept edge to the done pulse: one SETUP and one HIGH
    // phase per bit, then LATCH and GAP.
    function automatic int unsigned frame_cycles(input int unsigned bit_width,
                                                 input int unsigned half_period);
        return (2 * bit_width + 2) * half_period;
    endfunction

endpackage

// File: rtl/gamepad_pmod_phase_timer.sv
// Phase timer for the Gamepad Pmod emitter.
// Loaded at the start of every waveform phase, it counts down HALF_PERIOD
// cycles and raises phase_end_c in the last cycle of the phase.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : (re)start a phase; counter takes HALF_PERIOD-1
//   run          : a phase is in progress (emitter not idle)
//   phase_end_c  : combinational tick, high in the final cycle of a phase
module gamepad_pmod_phase_timer
    import gamepad_pmod_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic phase_end_c
);

    localparam int unsigned CNT_W = $clog2(HALF_PERIOD) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over the decrement so a phase can restart on its own end tick.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(HALF_PERIOD - 1);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_c = run && (cnt_q == '0);

endmodule

// File: rtl/gamepad_pmod_emitter.sv
// Transmit end of the Gamepad Pmod link. Accepts one controller-state word
// over a valid/ready handshake and serialises it MSB first as pmod_data with
// a pmod_clk rising edge per bit, followed by a pmod_latch strobe and a gap.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_data   : word to send, bit BIT_WIDTH-1 first
//   frame_valid  : send request; accepted when frame_ready is high
//   frame_ready  : emitter idle (combinational from state)
//   busy         : frame in flight (cycle after accept until done)
//   done         : one-cycle pulse as the emitter returns to idle
//   pmod_data    : serial data, registered
//   pmod_clk     : serial clock, registered, idles low
//   pmod_latch   : latch strobe, registered, idles low
module gamepad_pmod_emitter
    import gamepad_pmod_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = GAMEPAD_BITS,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pmod_data,
    output logic                 pmod_clk,
    output logic                 pmod_latch
);

    localparam int unsigned BCNT_W = $clog2(BIT_WIDTH);

    state_t               state_q,      state_d;
    logic [BIT_WIDTH-1:0] shreg_q,      shreg_d;
    logic [BCNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic                 pmod_data_q,  pmod_data_d;
    logic                 pmod_clk_q,   pmod_clk_d;
    logic                 pmod_latch_q, pmod_latch_d;
    logic                 done_q,       done_d;
    logic                 busy_q,       busy_d;

    logic                 tmr_load;
    logic                 tmr_run;
    logic                 phase_end_c;

    // Per-phase duration counter.
    gamepad_pmod_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (tmr_load),
        .run         (tmr_run),
        .phase_end_c (phase_end_c)
    );

    assign tmr_run = (state_q != IDLE);

    // Next-state and next-output logic. Every pmod_* change is decided here
    // and lands on the same edge as the state change, so outputs stay glitch
    // free and data only moves together with (or while) pmod_clk is low.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        pmod_data_d  = pmod_data_q;
        pmod_clk_d   = pmod_clk_q;
        pmod_latch_d = pmod_latch_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;

        case (state_q)
            IDLE: begin
                pmod_data_d  = 1'b0;
                pmod_clk_d   = 1'b0;
                pmod_latch_d = 1'b0;
                if (frame_valid) begin
                    shreg_d     = frame_data;
                    bit_cnt_d   = BCNT_W'(BIT_WIDTH - 1);
                    pmod_data_d = shreg_d[BIT_WIDTH-1];
                    tmr_load    = 1'b1;
                    state_d     = SETUP;
                end
            end

            SETUP: begin
                if (phase_end_c) begin
                    pmod_clk_d = 1'b1;
                    tmr_load   = 1'b1;
                    state_d    = HIGH;
                end
            end

            HIGH: begin
                if (phase_end_c) begin
                    pmod_clk_d = 1'b0;
                    tmr_load   = 1'b1;
                    if (bit_cnt_q == '0) begin
                        pmod_data_d  = 1'b0;
                        pmod_latch_d = 1'b1;
                        state_d      = LATCH;
                    end else begin
                        // Next bit goes out on the falling edge.
                        shreg_d     = shreg_q << 1;
                        bit_cnt_d   = bit_cnt_q - BCNT_W'(1);
                        pmod_data_d = shreg_d[BIT_WIDTH-1];
                        state_d     = SETUP;
                    end
                end
            end

            LATCH: begin
                if (phase_end_c) begin
                    pmod_latch_d = 1'b0;
                    tmr_load     = 1'b1;
                    state_d      = GAP;
                end
            end

            GAP: begin
                if (phase_end_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                pmod_data_d  = 1'b0;
                pmod_clk_d   = 1'b0;
                pmod_latch_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            pmod_data_q  <= 1'b0;
            pmod_clk_q   <= 1'b0;
            pmod_latch_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            pmod_data_q  <= pmod_data_d;
            pmod_clk_q   <= pmod_clk_d;
            pmod_latch_q <= pmod_latch_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign frame_ready = (state_q == IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign pmod_data   = pmod_data_q;
    assign pmod_clk    = pmod_clk_q;
    assign pmod_latch  = pmod_latch_q;

endmodule

// File: tb/tb_gamepad_pmod_emitter.sv
// Bench for gamepad_pmod_emitter: two instances (HALF_PERIOD 2 and 1) are
// decoded by a behavioural gamepad receiver and compared with the sent words.
module tb_gamepad_pmod_emitter;
    import gamepad_pmod_pkg::*;

    localparam int unsigned BW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] fdata  [2];
    logic          fvalid [2];
    logic          ready  [2];
    logic          busy   [2];
    logic          done   [2];
    logic          pdata  [2];
    logic          pclk   [2];
    logic          platch [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gamepad_pmod_emitter #(
            .BIT_WIDTH   (BW),
            .HALF_PERIOD ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_data  (fdata[g]),
            .frame_valid (fvalid[g]),
            .frame_ready (ready[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .pmod_data   (pdata[g]),
            .pmod_clk    (pclk[g]),
            .pmod_latch  (platch[g])
        );
    end

    function automatic int hp(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural receiver: shift data on each pmod_clk rise, commit the last
    // BW bits on each latch rise. Sampled 1 time unit after the clock edge.
    logic [BW-1:0] rx_shift [2];
    logic [BW-1:0] rx_word  [2];
    int            rx_bits  [2];
    int            rx_lat   [2];
    int            hi_run   [2];
    logic          clk_p    [2];
    logic          lat_p    [2];
    logic          dat_p    [2];
    bit            skip_run;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pclk[d] && clk_p[d])
                chk("data_stable_while_clk_high", 32'(pdata[d]), 32'(dat_p[d]));
            if (pclk[d] && !clk_p[d]) begin
                rx_shift[d] = {rx_shift[d][BW-2:0], pdata[d]};
                rx_bits[d]++;
            end
            if (pclk[d]) begin
                hi_run[d]++;
            end else begin
                if (clk_p[d] && !skip_run)
                    chk("clk_high_len", 32'(hi_run[d]), 32'(hp(d)));
                hi_run[d] = 0;
            end
            if (platch[d] && !lat_p[d]) begin
                rx_word[d] = rx_shift[d];
                rx_lat[d]++;
            end
            clk_p[d] = pclk[d];
            lat_p[d] = platch[d];
            dat_p[d] = pdata[d];
        end
    end

    task automatic wait_ready(input int d);
        int t;
        t = 0;
        while (!ready[d] && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(ready[d]), 32'd1);
    endtask

    // Entered at a negedge with frame_valid/frame_data already driven to w.
    // Returns at the negedge of the done cycle; if chain, drives nxt there.
    task automatic run_frame(input int d, input logic [BW-1:0] w,
                             input bit chain, input logic [BW-1:0] nxt);
        int t0, bits0, lat0, t;
        bits0 = rx_bits[d];
        lat0  = rx_lat[d];
        @(negedge clk);
        t0 = cyc;
        chk("accept_busy", 32'(busy[d]), 32'd1);
        chk("accept_ready", 32'(ready[d]), 32'd0);
        chk("done_one_cycle", 32'(done[d]), 32'd0);
        fvalid[d] = 1'b0;
        fdata[d]  = BW'($urandom);
        repeat ($urandom_range(2, 20)) @(negedge clk);
        fvalid[d] = 1'b1;
        fdata[d]  = 24'h0000AA;
        @(negedge clk);
        chk("busy_ignores_valid", 32'(ready[d]), 32'd0);
        fvalid[d] = 1'b0;
        fdata[d]  = BW'($urandom);
        t = 0;
        while (!done[d] && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("frame_len", 32'(cyc - t0), 32'(frame_cycles(BW, hp(d))));
        chk("done_ready", 32'(ready[d]), 32'd1);
        chk("done_not_busy", 32'(busy[d]), 32'd0);
        chk("rx_word", 32'(rx_word[d]), 32'(w));
        chk("clk_rises", 32'(rx_bits[d] - bits0), 32'(BW));
        chk("latch_pulses", 32'(rx_lat[d] - lat0), 32'd1);
        if (chain) begin
            fvalid[d] = 1'b1;
            fdata[d]  = nxt;
        end
    endtask

    task automatic send(input int d, input logic [BW-1:0] w);
        wait_ready(d);
        fdata[d]  = w;
        fvalid[d] = 1'b1;
        run_frame(d, w, 1'b0, '0);
    endtask

    initial begin
        int t, lat0, bits0;
        logic [BW-1:0] w, w2;
        skip_run = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fdata[d]    = '0;
            fvalid[d]   = 1'b0;
            rx_shift[d] = '0;
            rx_word[d]  = '0;
            rx_bits[d]  = 0;
            rx_lat[d]   = 0;
            hi_run[d]   = 0;
            clk_p[d]    = 1'b0;
            lat_p[d]    = 1'b0;
            dat_p[d]    = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: static low waveforms, ready, never busy or done.
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk("idle_outputs", 32'({pdata[d], pclk[d], platch[d], busy[d], done[d], ready[d]}),
                    32'b000001);
        end

        // Basic frame on both timings, including the single-cycle phases.
        send(0, 24'hABC123);
        send(1, 24'h800001);

        // Back-to-back with controller-absent patterns.
        wait_ready(0);
        fdata[0]  = 24'hFFF5A5;
        fvalid[0] = 1'b1;
        run_frame(0, 24'hFFF5A5, 1'b1, 24'h000FFF);
        chk("ctrl2_absent", 32'(rx_word[0][23:12]), 32'(CTRL_ABSENT));
        run_frame(0, 24'h000FFF, 1'b0, '0);
        chk("ctrl1_absent", 32'(rx_word[0][11:0]), 32'(CTRL_ABSENT));

        // Reset in the middle of a frame must not disturb the received word.
        send(0, 24'h654321);
        wait_ready(0);
        lat0      = rx_lat[0];
        bits0     = rx_bits[0];
        fdata[0]  = 24'h123456;
        fvalid[0] = 1'b1;
        @(negedge clk);
        fvalid[0] = 1'b0;
        t = 0;
        while ((rx_bits[0] - bits0) < 10 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("reached_10th_rise", 32'(rx_bits[0] - bits0), 32'd10);
        skip_run = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({pdata[0], pclk[0], platch[0], busy[0], done[0]}), 32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_keeps_word", 32'(rx_word[0]), 32'h654321);
        chk("rst_no_latch", 32'(rx_lat[0] - lat0), 32'd0);
        skip_run = 1'b0;
        send(0, 24'h123456);

        // Randomised traffic, sometimes chained.
        for (int i = 0; i < 16; i++) begin
            int d;
            d  = int'($urandom_range(0, 1));
            w  = BW'($urandom);
            w2 = BW'($urandom);
            wait_ready(d);
            fdata[d]  = w;
            fvalid[d] = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                run_frame(d, w, 1'b1, w2);
                run_frame(d, w2, 1'b0, '0);
            end else begin
                run_frame(d, w, 1'b0, '0);
            end
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
